mmio_exit_console: RTL and testbench

- Memory-mapped peripheral on the data-memory bus of single_cycle_machine, directly downstream of the CPU's store path.
- Captures character writes into a FIFO, drained by the testbench or a UART model.
- Latches a program exit code and raises halted/done, so the bench ends simulation on completion rather than on a cycle-limit timeout.
- Runs a cycle counter with a timeout flag so the run limit lives in hardware, not in the bench.

---
 rtl/mmio_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/mmio_exit_console.sv | 125 ++++++++++++
 tb/tb_mmio_exit_console.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Register offsets, STATUS bit positions and status packing for
//            the exit/console MMIO window.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_EXIT   = 4'h8;
    localparam logic [3:0] OFF_CYCLE  = 4'hC;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_HALTED    = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_TIMEOUT   = 4;
    localparam int ST_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       halted,
        input logic       overflow,
        input logic       timeout,
        input logic [7:0] count
    );
        logic [31:0] w_word;
        w_word                        = '0;
        w_word[ST_EMPTY]              = empty;
        w_word[ST_FULL]               = full;
        w_word[ST_HALTED]             = halted;
        w_word[ST_OVERFLOW]           = overflow;
        w_word[ST_TIMEOUT]            = timeout;
        w_word[ST_COUNT_LSB +: 8]     = count;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO; a pop on a full FIFO frees room for a push
//            in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_exit_console.sv
`default_nettype none
// ============================================================================
// Module   : mmio_exit_console
// Purpose  : MMIO console FIFO, exit-code latch and run-limit cycle counter
//            sitting on the data-memory bus.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_exit_console
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_write_enable,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        bus_hit,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted,
    output logic [31:0] exit_code,
    output logic        done,
    output logic        timeout,
    output logic        overflow,
    output logic [31:0] cycle_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    w_offset;
    logic          w_wr;
    logic          w_push;
    logic          w_exit_wr;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_count_ext;
    logic [31:0]   w_status;

    logic          r_halted;
    logic [31:0]   r_exit_code;
    logic          r_timeout;
    logic          r_overflow;
    logic [31:0]   r_cycle_count;

    assign w_offset    = bus_addr[3:0];
    assign bus_hit     = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr        = bus_write_enable && bus_hit;
    // A halted machine accepts no further console or exit traffic.
    assign w_push      = w_wr && (w_offset == OFF_TXDATA) && !r_halted;
    assign w_exit_wr   = w_wr && (w_offset == OFF_EXIT) && !r_halted;
    assign w_count_ext = 32'(w_count);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (tx_ready),
        .wdata (bus_write_data[7:0]),
        .rdata (tx_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halted      <= 1'b0;
            r_exit_code   <= '0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            if (w_exit_wr) begin
                r_halted    <= 1'b1;
                r_exit_code <= bus_write_data;
            end
            // Full FIFO only takes the byte if the consumer pops this edge.
            if (w_push && w_full && !tx_ready) begin
                r_overflow <= 1'b1;
            end
            if (!r_halted && !r_timeout) begin
                if (r_cycle_count + 32'd1 >= TIMEOUT_CYCLES) begin
                    r_cycle_count <= TIMEOUT_CYCLES;
                    r_timeout     <= 1'b1;
                end else begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                end
            end
        end
    end

    assign w_status = pack_status(w_empty, w_full, r_halted, r_overflow,
                                  r_timeout, w_count_ext[7:0]);

    always_comb begin
        bus_read_data = '0;
        if (bus_hit) begin
            case (w_offset)
                OFF_STATUS: bus_read_data = w_status;
                OFF_EXIT:   bus_read_data = r_exit_code;
                OFF_CYCLE:  bus_read_data = r_cycle_count;
                default:    bus_read_data = '0;
            endcase
        end
    end

    assign tx_valid    = !w_empty;
    assign halted      = r_halted;
    assign exit_code   = r_exit_code;
    assign done        = r_halted && w_empty;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_mmio_exit_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_exit_console
// Purpose  : Scoreboard bench for mmio_exit_console plus a short-timeout
//            instance for the run-limit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_exit_console;
    import mmio_pkg::*;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 16;

    logic        clock;
    logic        reset;
    logic        bus_write_enable;
    logic [31:0] bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_hit;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halted;
    logic [31:0] exit_code;
    logic        done;
    logic        timeout;
    logic        overflow;
    logic [31:0] cycle_count;

    logic [31:0] t_rdata;
    logic        t_hit;
    logic        t_valid;
    logic [7:0]  t_data;
    logic        t_halted;
    logic [31:0] t_exit;
    logic        t_done;
    logic        t_timeout;
    logic        t_overflow;
    logic [31:0] t_cycles;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  q[$];
    logic        m_halted;
    logic [31:0] m_exit;
    logic        m_ovf;
    logic [31:0] m_cycles;

    mmio_exit_console #(
        .BASE_ADDR      (BASE),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (32'd100000)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .bus_write_enable (bus_write_enable),
        .bus_addr         (bus_addr),
        .bus_write_data   (bus_write_data),
        .bus_read_data    (bus_read_data),
        .bus_hit          (bus_hit),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .halted           (halted),
        .exit_code        (exit_code),
        .done             (done),
        .timeout          (timeout),
        .overflow         (overflow),
        .cycle_count      (cycle_count)
    );

    mmio_exit_console #(
        .BASE_ADDR      (BASE),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (32'd20)
    ) u_tmo (
        .clock            (clock),
        .reset            (reset),
        .bus_write_enable (1'b0),
        .bus_addr         ({BASE[31:4], OFF_CYCLE}),
        .bus_write_data   (32'h0),
        .bus_read_data    (t_rdata),
        .bus_hit          (t_hit),
        .tx_valid         (t_valid),
        .tx_data          (t_data),
        .tx_ready         (1'b0),
        .halted           (t_halted),
        .exit_code        (t_exit),
        .done             (t_done),
        .timeout          (t_timeout),
        .overflow         (t_overflow),
        .cycle_count      (t_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        logic [31:0] v;
        v = 32'h0;
        if (addr[31:4] == BASE[31:4]) begin
            case (addr[3:0])
                OFF_STATUS: v = pack_status(q.size() == 0, q.size() == DEPTH, m_halted,
                                            m_ovf, 1'b0, 8'(q.size()));
                OFF_EXIT:   v = m_exit;
                OFF_CYCLE:  v = m_cycles;
                default:    v = 32'h0;
            endcase
        end
        return v;
    endfunction

    // Scoreboard: compare current outputs, then advance the model to the next edge.
    always @(negedge clock) begin
        logic w_hit;
        if (!reset) begin
            q.delete();
            m_halted = 1'b0;
            m_exit   = 32'h0;
            m_ovf    = 1'b0;
            m_cycles = 32'h0;
        end
        check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
        check("halted", 32'(halted), 32'(m_halted));
        check("exit_code", exit_code, m_exit);
        check("done", 32'(done), 32'(m_halted && q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("timeout", 32'(timeout), 32'h0);
        check("cycle_count", cycle_count, m_cycles);
        w_hit = (bus_addr[31:4] == BASE[31:4]);
        check("bus_hit", 32'(bus_hit), 32'(w_hit));
        check("rdata", bus_read_data, exp_rdata(bus_addr));
        if (reset) begin
            if (!m_halted) m_cycles++;
            if (tx_ready && q.size() != 0) void'(q.pop_front());
            if (w_hit && bus_write_enable && !m_halted) begin
                if (bus_addr[3:0] == OFF_TXDATA) begin
                    if (q.size() < DEPTH) q.push_back(bus_write_data[7:0]);
                    else m_ovf = 1'b1;
                end else if (bus_addr[3:0] == OFF_EXIT) begin
                    m_halted = 1'b1;
                    m_exit   = bus_write_data;
                end
            end
        end
    end

    // All tasks start and end at one time unit after a rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic rdy);
        bus_write_enable = 1'b1;
        bus_addr         = addr;
        bus_write_data   = data;
        tx_ready         = rdy;
        @(posedge clock);
        #1;
        bus_write_enable = 1'b0;
        tx_ready         = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        tx_ready = rdy;
        repeat (n) @(posedge clock);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_addr = addr;
        #1;
        check(tag, bus_read_data, exp);
    endtask

    initial begin
        logic [31:0] c0;
        reset            = 1'b0;
        bus_write_enable = 1'b0;
        bus_addr         = {BASE[31:4], OFF_STATUS};
        bus_write_data   = 32'h0;
        tx_ready         = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Reset state and free-running counter
        read_check("status_reset", {BASE[31:4], OFF_STATUS}, 32'h0000_0001);
        check("tx_valid_reset", 32'(tx_valid), 32'h0);
        bus_addr = {BASE[31:4], OFF_CYCLE};
        #1;
        c0 = bus_read_data;
        idle(5, 1'b0);
        read_check("cycle_step", {BASE[31:4], OFF_CYCLE}, c0 + 32'd5);

        // Two characters, then drain
        bus_write({BASE[31:4], OFF_TXDATA}, 32'h48, 1'b0);
        bus_write({BASE[31:4], OFF_TXDATA}, 32'h69, 1'b0);
        read_check("status_two", {BASE[31:4], OFF_STATUS}, 32'h0000_0200);
        check("head_H", 32'(tx_data), 32'h48);
        idle(1, 1'b1);
        check("head_i", 32'(tx_data), 32'h69);
        idle(1, 1'b1);
        check("drained", 32'(tx_valid), 32'h0);

        // Overflow: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) bus_write({BASE[31:4], OFF_TXDATA}, 32'(i), 1'b0);
        read_check("status_ovf", {BASE[31:4], OFF_STATUS}, 32'h0000_100A);
        idle(20, 1'b1);
        do_reset();
        for (int i = 0; i < 16; i++) bus_write({BASE[31:4], OFF_TXDATA}, 32'(i), 1'b0);
        bus_write({BASE[31:4], OFF_TXDATA}, 32'h10, 1'b1);
        read_check("status_full_pop", {BASE[31:4], OFF_STATUS}, 32'h0000_1002);
        idle(20, 1'b1);

        // Exit latch: first write wins, later traffic ignored
        do_reset();
        bus_write({BASE[31:4], OFF_TXDATA}, 32'h41, 1'b0);
        bus_write({BASE[31:4], OFF_EXIT}, 32'h0000_002A, 1'b0);
        bus_write({BASE[31:4], OFF_EXIT}, 32'h5, 1'b0);
        bus_write({BASE[31:4], OFF_TXDATA}, 32'h42, 1'b0);
        check("exit_code_42", exit_code, 32'd42);
        check("done_pending", 32'(done), 32'h0);
        read_check("status_halt", {BASE[31:4], OFF_STATUS}, 32'h0000_0104);
        idle(3, 1'b0);
        idle(1, 1'b1);
        check("done_after_pop", 32'(done), 32'h1);
        read_check("exit_read", {BASE[31:4], OFF_EXIT}, 32'd42);

        // Mid-run asynchronous reset with queued bytes and halt set
        do_reset();
        for (int i = 1; i <= 3; i++) bus_write({BASE[31:4], OFF_TXDATA}, 32'(i), 1'b0);
        bus_write({BASE[31:4], OFF_EXIT}, 32'h7, 1'b0);
        check("pre_reset_halted", 32'(halted), 32'h1);
        bus_addr = {BASE[31:4], OFF_STATUS};
        #1;
        reset = 1'b0;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'h0);
        check("async_halted", 32'(halted), 32'h0);
        check("async_exit", exit_code, 32'h0);
        check("async_cycles", cycle_count, 32'h0);
        check("async_status", bus_read_data, 32'h0000_0001);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Misaligned and out-of-window accesses
        bus_write(BASE + 32'h2, 32'h55, 1'b0);
        bus_write(BASE + 32'h10, 32'h55, 1'b0);
        read_check("status_untouched", {BASE[31:4], OFF_STATUS}, 32'h0000_0001);
        read_check("misaligned_read", BASE + 32'h2, 32'h0);
        read_check("outside_read", BASE + 32'h10, 32'h0);
        check("outside_hit", 32'(bus_hit), 32'h0);
        bus_addr = {BASE[31:4], OFF_STATUS};

        // Short-timeout instance: counter saturates at 20
        do_reset();
        for (int k = 0; k <= 25; k++) begin
            @(negedge clock);
            check("tmo_cycles", t_cycles, (k < 20) ? 32'(k) : 32'd20);
            check("tmo_flag", 32'(t_timeout), 32'(k >= 20));
            check("tmo_read", t_rdata, (k < 20) ? 32'(k) : 32'd20);
        end
        @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
